spi_mem_sched: RTL and testbench

- Two-requester scheduler in front of spi_mem. Arbitrates between two byte read/write clients, round-robin.
- Inserts the CMD_WREN transaction automatically ahead of every write.
- Drives the spi_mem en/valid handshake and returns read data or error per request.
- Sits between the system-side clients and the single spi_mem instance that owns the FM25L16 SPI pins.

---
 rtl/spi_mem_sched_if.sv | 50 +++++
 rtl/spi_mem_sched.sv | 169 ++++++++++++++++
 tb/tb_spi_mem_sched.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_sched_if.sv
// Bundles the two client request/response channels and the spi_mem
// en/valid handshake into one interface. The scheduler connects through
// the slave modport; the environment (clients plus memory) uses master.
interface spi_mem_sched_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic              rsp0_err;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic              rsp1_err;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              mem_en;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_valid;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
        output mem_en, mem_cmd, mem_addr, mem_wr_data,
        input  mem_rd_data, mem_valid
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
        input  mem_en, mem_cmd, mem_addr, mem_wr_data,
        output mem_rd_data, mem_valid
    );
endinterface

// File: rtl/spi_mem_sched.sv
// Round-robin scheduler for two byte clients in front of one spi_mem.
// Each write is optionally preceded by a WREN transaction; every spi_mem
// phase is a full en/valid four-phase handshake with an optional timeout.
module spi_mem_sched #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int AUTO_WREN = 1,
    parameter int TIMEOUT   = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_mem_sched_if.slave  bus,
    output logic            busy
);
    // Command encodings shared with spi_mem (spi_mem_cmd.vh)
    localparam logic [1:0] CMD_WREN  = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE, WREN_ISSUE, WREN_REL, OP_ISSUE, OP_REL, ABORT, RESP
    } state_t;

    state_t            state, state_nx;
    logic              rr_last;
    logic              cli_q, we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              rsp0_err_q, rsp1_err_q;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

    logic              grant_any, grant_id, accept, timed_out, sel_we;
    logic              in_issue, enter_issue;

    // Pick a client: alternate under contention, otherwise take whoever asks
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~rr_last;
        end else if (bus.req0_valid) begin
            grant_any = 1'b1;
        end else if (bus.req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign accept      = rst_n && (state == IDLE) && !bus.mem_valid && grant_any;
    assign sel_we      = grant_id ? bus.req1_we : bus.req0_we;
    assign in_issue    = (state == WREN_ISSUE) || (state == OP_ISSUE);
    assign enter_issue = (state_nx != state) && ((state_nx == WREN_ISSUE) || (state_nx == OP_ISSUE));
    assign timed_out   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST) && !bus.mem_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; a valid arriving on the timeout cycle still counts as success
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (accept) state_nx = (sel_we && AUTO_WREN != 0) ? WREN_ISSUE : OP_ISSUE;
            WREN_ISSUE: if (bus.mem_valid) state_nx = WREN_REL;
                        else if (timed_out) state_nx = ABORT;
            WREN_REL:   if (!bus.mem_valid) state_nx = OP_ISSUE;
            OP_ISSUE:   if (bus.mem_valid) state_nx = OP_REL;
                        else if (timed_out) state_nx = ABORT;
            OP_REL:     if (!bus.mem_valid) state_nx = RESP;
            ABORT:      if (!bus.mem_valid) state_nx = RESP;
            RESP:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // Per-phase timeout counter, restarted on every entry to an issue state
    always_ff @(posedge clk) begin
        if (!rst_n)           tmo_cnt <= '0;
        else if (enter_issue) tmo_cnt <= '0;
        else if (in_issue)    tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Request latch, read capture, error flag and held response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last      <= 1'b1;
            cli_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            if (accept) begin
                rr_last <= grant_id;
                cli_q   <= grant_id;
                we_q    <= sel_we;
                addr_q  <= grant_id ? bus.req1_addr  : bus.req0_addr;
                wdata_q <= grant_id ? bus.req1_wdata : bus.req0_wdata;
                rdata_q <= '0;
            end
            if (state == OP_ISSUE && bus.mem_valid)
                rdata_q <= we_q ? '0 : bus.mem_rd_data;
            if (in_issue && timed_out)
                err_q <= 1'b1;
            if (state == RESP)
                err_q <= 1'b0;
            if (state_nx == RESP && state != RESP) begin
                if (cli_q) begin
                    rsp1_err_q   <= err_q;
                    rsp1_rdata_q <= err_q ? '0 : rdata_q;
                end else begin
                    rsp0_err_q   <= err_q;
                    rsp0_rdata_q <= err_q ? '0 : rdata_q;
                end
            end
        end
    end

    // Output decode from the current state
    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_cmd     = 2'b00;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.rsp0_valid  = 1'b0;
        bus.rsp1_valid  = 1'b0;
        busy            = (state != IDLE);
        case (state)
            IDLE: begin
                bus.req0_ready = accept && !grant_id;
                bus.req1_ready = accept && grant_id;
            end
            WREN_ISSUE: begin
                bus.mem_en  = 1'b1;
                bus.mem_cmd = CMD_WREN;
            end
            OP_ISSUE: begin
                bus.mem_en      = 1'b1;
                bus.mem_cmd     = we_q ? CMD_WRITE : CMD_READ;
                bus.mem_addr    = addr_q;
                bus.mem_wr_data = wdata_q;
            end
            RESP: begin
                bus.rsp0_valid = !cli_q;
                bus.rsp1_valid = cli_q;
            end
            default: ;
        endcase
    end

    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_err   = rsp1_err_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
endmodule

// File: tb/tb_spi_mem_sched.sv
// Directed bench for spi_mem_sched: a handshake-level spi_mem emulator
// with a write-enable latch backs the main instance (AUTO_WREN=1,
// TIMEOUT=16); a second instance with AUTO_WREN=0 has a trivial responder.
module tb_spi_mem_sched;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam logic [1:0] CMD_WREN  = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy, busy_nw;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    spi_mem_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();
    spi_mem_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc_nw ();

    spi_mem_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_WREN(1), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave), .busy(busy));

    spi_mem_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_WREN(0), .TIMEOUT(TIMEOUT)) u_dut_nw (
        .clk(clk), .rst_n(rst_n), .bus(ifc_nw.slave), .busy(busy_nw));

    // spi_mem emulator: memory, WEL latch, programmable latency or stall, command log
    logic [7:0] emu_mem [64];
    logic       emu_loaded = 1'b0;
    logic       emu_wel    = 1'b0;
    logic       emu_stall  = 1'b0;
    int         emu_lat    = 2;
    int         emu_cnt    = 0;
    int         emu_nlog   = 0;
    logic [1:0] log_cmd  [1024];
    logic [5:0] log_addr [1024];
    logic [7:0] log_data [1024];

    always @(posedge clk) begin
        if (!emu_loaded) begin
            for (int i = 0; i < 64; i++) emu_mem[i] <= 8'(i) ^ 8'hB0;
            emu_loaded      <= 1'b1;
            ifc.mem_valid   <= 1'b0;
            ifc.mem_rd_data <= 8'h00;
        end else if (ifc.mem_en === 1'b1 && ifc.mem_valid === 1'b0) begin
            if (!emu_stall) begin
                if (emu_cnt >= emu_lat) begin
                    ifc.mem_valid <= 1'b1;
                    emu_cnt       <= 0;
                    log_cmd [emu_nlog % 1024] <= ifc.mem_cmd;
                    log_addr[emu_nlog % 1024] <= ifc.mem_addr;
                    log_data[emu_nlog % 1024] <= ifc.mem_wr_data;
                    emu_nlog <= emu_nlog + 1;
                    case (ifc.mem_cmd)
                        CMD_WREN:  emu_wel <= 1'b1;
                        CMD_READ:  ifc.mem_rd_data <= emu_mem[ifc.mem_addr];
                        CMD_WRITE: begin
                            if (emu_wel) emu_mem[ifc.mem_addr] <= ifc.mem_wr_data;
                            emu_wel <= 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    emu_cnt <= emu_cnt + 1;
                end
            end
        end else if (ifc.mem_en !== 1'b1) begin
            ifc.mem_valid <= 1'b0;
            emu_cnt       <= 0;
        end
    end

    // Trivial one-cycle responder for the AUTO_WREN=0 instance, counting frames
    int         nw_frames = 0;
    logic [1:0] nw_last_cmd = 2'b00;
    always @(posedge clk) begin
        ifc_nw.mem_valid   <= (ifc_nw.mem_en === 1'b1);
        ifc_nw.mem_rd_data <= 8'h00;
        if (ifc_nw.mem_en === 1'b1 && ifc_nw.mem_valid === 1'b0) begin
            nw_frames   <= nw_frames + 1;
            nw_last_cmd <= ifc_nw.mem_cmd;
        end
    end

    // Monitors: grant order, response stream and length of each mem_en burst
    int         g_n = 0;
    logic       g_log [64];
    int         rsp_n = 0;
    logic       rsp_cli [64];
    logic [7:0] rsp_dat [64];
    int         en_run = 0;
    int         en_last_run = 0;

    always @(negedge clk) begin
        if (ifc.req0_valid === 1'b1 && ifc.req0_ready === 1'b1) begin
            g_log[g_n % 64] <= 1'b0;
            g_n <= g_n + 1;
        end else if (ifc.req1_valid === 1'b1 && ifc.req1_ready === 1'b1) begin
            g_log[g_n % 64] <= 1'b1;
            g_n <= g_n + 1;
        end
        if (ifc.rsp0_valid === 1'b1) begin
            rsp_cli[rsp_n % 64] <= 1'b0;
            rsp_dat[rsp_n % 64] <= ifc.rsp0_rdata;
            rsp_n <= rsp_n + 1;
        end else if (ifc.rsp1_valid === 1'b1) begin
            rsp_cli[rsp_n % 64] <= 1'b1;
            rsp_dat[rsp_n % 64] <= ifc.rsp1_rdata;
            rsp_n <= rsp_n + 1;
        end
        if (ifc.mem_en === 1'b1) begin
            en_run <= en_run + 1;
        end else if (en_run != 0) begin
            en_last_run <= en_run;
            en_run      <= 0;
        end
    end

    logic [7:0] exp_mem [64];

    // Runs one request on the main instance and reports what came back
    task automatic do_req(input bit cli, input bit we, input logic [5:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic er, output bit ok,
                          output bit pulse1, output bit other_quiet);
        int k;
        ok = 1'b0; pulse1 = 1'b0; other_quiet = 1'b0; rd = 'x; er = 'x;
        @(posedge clk); #1;
        if (cli) begin
            ifc.req1_valid = 1'b1; ifc.req1_we = we; ifc.req1_addr = addr; ifc.req1_wdata = wd;
        end else begin
            ifc.req0_valid = 1'b1; ifc.req0_we = we; ifc.req0_addr = addr; ifc.req0_wdata = wd;
        end
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((cli ? ifc.req1_ready : ifc.req0_ready) === 1'b1) break;
        end
        @(posedge clk); #1;
        if (cli) ifc.req1_valid = 1'b0;
        else     ifc.req0_valid = 1'b0;
        if (k == 200) return;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if ((cli ? ifc.rsp1_valid : ifc.rsp0_valid) === 1'b1) break;
        end
        if (k == 400) return;
        rd          = cli ? ifc.rsp1_rdata : ifc.rsp0_rdata;
        er          = cli ? ifc.rsp1_err : ifc.rsp0_err;
        other_quiet = ((cli ? ifc.rsp0_valid : ifc.rsp1_valid) === 1'b0);
        @(negedge clk);
        pulse1      = ((cli ? ifc.rsp1_valid : ifc.rsp0_valid) === 1'b0);
        ok          = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ifc.mem_en, ifc.mem_cmd, ifc.mem_addr, ifc.mem_wr_data} !== 17'h0) begin
            n_err++;
            $display("[TB] FAIL reset_mem_bus got %h want 0", {ifc.mem_en, ifc.mem_cmd, ifc.mem_addr, ifc.mem_wr_data});
        end
        n_vec++;
        if ({ifc.req0_ready, ifc.req1_ready, ifc.rsp0_valid, ifc.rsp1_valid} !== 4'b0) begin
            n_err++;
            $display("[TB] FAIL reset_handshake got %b want 0000", {ifc.req0_ready, ifc.req1_ready, ifc.rsp0_valid, ifc.rsp1_valid});
        end
        n_vec++;
        if ({ifc.rsp0_err, ifc.rsp0_rdata, ifc.rsp1_err, ifc.rsp1_rdata} !== 18'h0) begin
            n_err++;
            $display("[TB] FAIL reset_rsp_data got %h want 0", {ifc.rsp0_err, ifc.rsp0_rdata, ifc.rsp1_err, ifc.rsp1_rdata});
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_busy got %b want 0", busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        logic [7:0] rd; logic er; bit ok, p1, oq; int n0;
        n0 = emu_nlog;
        do_req(1'b0, 1'b0, 6'h15, 8'h00, rd, er, ok, p1, oq);
        n_vec++;
        if (!ok || rd !== 8'hA5 || er !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL read_rsp got ok=%0d rdata=%h err=%b want ok=1 rdata=a5 err=0", ok, rd, er);
        end
        n_vec++;
        if (!p1 || !oq) begin
            n_err++;
            $display("[TB] FAIL read_pulse got single=%0d other_quiet=%0d want 1 1", p1, oq);
        end
        n_vec++;
        if (emu_nlog - n0 != 1 || log_cmd[n0 % 1024] !== CMD_READ || log_addr[n0 % 1024] !== 6'h15) begin
            n_err++;
            $display("[TB] FAIL read_frames got n=%0d cmd=%b addr=%h want n=1 cmd=10 addr=15",
                     emu_nlog - n0, log_cmd[n0 % 1024], log_addr[n0 % 1024]);
        end
    endtask

    task automatic test_write();
        logic [7:0] rd; logic er; bit ok, p1, oq; int n0;
        n0 = emu_nlog;
        do_req(1'b1, 1'b1, 6'h3F, 8'h5C, rd, er, ok, p1, oq);
        exp_mem[6'h3F] = 8'h5C;
        n_vec++;
        if (!ok || er !== 1'b0 || rd !== 8'h00 || !p1 || !oq) begin
            n_err++;
            $display("[TB] FAIL write_rsp got ok=%0d err=%b rdata=%h single=%0d quiet=%0d want 1 0 00 1 1", ok, er, rd, p1, oq);
        end
        n_vec++;
        if (emu_nlog - n0 != 2 || log_cmd[n0 % 1024] !== CMD_WREN || log_cmd[(n0 + 1) % 1024] !== CMD_WRITE) begin
            n_err++;
            $display("[TB] FAIL write_wren_seq got n=%0d cmds=%b,%b want n=2 cmds=01,11",
                     emu_nlog - n0, log_cmd[n0 % 1024], log_cmd[(n0 + 1) % 1024]);
        end
        n_vec++;
        if (log_addr[(n0 + 1) % 1024] !== 6'h3F || log_data[(n0 + 1) % 1024] !== 8'h5C || emu_mem[63] !== 8'h5C) begin
            n_err++;
            $display("[TB] FAIL write_payload got addr=%h data=%h mem=%h want 3f 5c 5c",
                     log_addr[(n0 + 1) % 1024], log_data[(n0 + 1) % 1024], emu_mem[63]);
        end
        do_req(1'b0, 1'b0, 6'h3F, 8'h00, rd, er, ok, p1, oq);
        n_vec++;
        if (!ok || rd !== 8'h5C || er !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL write_readback got ok=%0d rdata=%h err=%b want 1 5c 0", ok, rd, er);
        end
    endtask

    task automatic test_no_wren();
        int f0, k; bit seen;
        f0 = nw_frames; seen = 1'b0;
        @(posedge clk); #1;
        ifc_nw.req0_valid = 1'b1; ifc_nw.req0_we = 1'b1; ifc_nw.req0_addr = 6'h3F; ifc_nw.req0_wdata = 8'h5C;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ifc_nw.req0_ready === 1'b1) break;
        end
        @(posedge clk); #1;
        ifc_nw.req0_valid = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ifc_nw.rsp0_valid === 1'b1) begin seen = 1'b1; break; end
        end
        n_vec++;
        if (!seen || ifc_nw.rsp0_err !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL nowren_rsp got seen=%0d err=%b want 1 0", seen, ifc_nw.rsp0_err);
        end
        n_vec++;
        if (nw_frames - f0 != 1 || nw_last_cmd !== CMD_WRITE) begin
            n_err++;
            $display("[TB] FAIL nowren_frames got n=%0d cmd=%b want n=1 cmd=11", nw_frames - f0, nw_last_cmd);
        end
    endtask

    task automatic test_contention();
        int g0, r0, k; bit stuck0, stuck1; logic [7:0] want;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        g0 = g_n; r0 = rsp_n; stuck0 = 1'b0; stuck1 = 1'b0;
        fork
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) begin
                    int w;
                    ifc.req0_valid = 1'b1; ifc.req0_we = 1'b0; ifc.req0_addr = 6'(i);
                    for (w = 0; w < 300; w++) begin
                        @(negedge clk);
                        if (ifc.req0_ready === 1'b1) break;
                    end
                    if (w == 300) stuck0 = 1'b1;
                    @(posedge clk); #1;
                end
                ifc.req0_valid = 1'b0;
            end
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) begin
                    int w;
                    ifc.req1_valid = 1'b1; ifc.req1_we = 1'b0; ifc.req1_addr = 6'(32 + i);
                    for (w = 0; w < 300; w++) begin
                        @(negedge clk);
                        if (ifc.req1_ready === 1'b1) break;
                    end
                    if (w == 300) stuck1 = 1'b1;
                    @(posedge clk); #1;
                end
                ifc.req1_valid = 1'b0;
            end
        join
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (rsp_n - r0 >= 8) break;
        end
        n_vec++;
        if (stuck0 || stuck1 || rsp_n - r0 != 8) begin
            n_err++;
            $display("[TB] FAIL contention_progress got stuck=%0d%0d rsps=%0d want 00 8", stuck0, stuck1, rsp_n - r0);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (g_log[(g0 + i) % 64] !== 1'(i % 2)) begin
                n_err++;
                $display("[TB] FAIL contention_grant[%0d] got %b want %0d", i, g_log[(g0 + i) % 64], i % 2);
            end
            want = (i % 2 == 0) ? exp_mem[i / 2] : exp_mem[32 + i / 2];
            n_vec++;
            if (rsp_cli[(r0 + i) % 64] !== 1'(i % 2) || rsp_dat[(r0 + i) % 64] !== want) begin
                n_err++;
                $display("[TB] FAIL contention_rsp[%0d] got cli=%b data=%h want cli=%0d data=%h",
                         i, rsp_cli[(r0 + i) % 64], rsp_dat[(r0 + i) % 64], i % 2, want);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] rd; logic er; bit ok, p1, oq;
        emu_stall = 1'b1;
        do_req(1'b0, 1'b0, 6'h05, 8'h00, rd, er, ok, p1, oq);
        emu_stall = 1'b0;
        n_vec++;
        if (!ok || er !== 1'b1 || rd !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL timeout_rsp got ok=%0d err=%b rdata=%h want 1 1 00", ok, er, rd);
        end
        n_vec++;
        if (en_last_run != TIMEOUT) begin
            n_err++;
            $display("[TB] FAIL timeout_en_cycles got %0d want %0d", en_last_run, TIMEOUT);
        end
        do_req(1'b1, 1'b0, 6'h06, 8'h00, rd, er, ok, p1, oq);
        n_vec++;
        if (!ok || er !== 1'b0 || rd !== 8'hB6) begin
            n_err++;
            $display("[TB] FAIL timeout_recover got ok=%0d err=%b rdata=%h want 1 0 b6", ok, er, rd);
        end
    endtask

    task automatic test_reset_midop();
        logic [7:0] rd; logic er; bit ok, p1, oq; int k, r0; bit en_seen;
        emu_lat = 20; en_seen = 1'b0;
        @(posedge clk); #1;
        ifc.req0_valid = 1'b1; ifc.req0_we = 1'b0; ifc.req0_addr = 6'h0A;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ifc.req0_ready === 1'b1) break;
        end
        @(posedge clk); #1;
        ifc.req0_valid = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifc.mem_en === 1'b1 && ifc.mem_cmd === CMD_READ) begin en_seen = 1'b1; break; end
        end
        r0 = rsp_n;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (!en_seen || ifc.mem_en !== 1'b0 || busy !== 1'b0 || ifc.rsp0_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midop_reset got in_op=%0d en=%b busy=%b rsp=%b want 1 0 0 0", en_seen, ifc.mem_en, busy, ifc.rsp0_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        emu_lat = 2;
        n_vec++;
        if (rsp_n != r0) begin
            n_err++;
            $display("[TB] FAIL midop_no_rsp got %0d responses want 0", rsp_n - r0);
        end
        do_req(1'b0, 1'b0, 6'h0A, 8'h00, rd, er, ok, p1, oq);
        n_vec++;
        if (!ok || er !== 1'b0 || rd !== 8'hBA) begin
            n_err++;
            $display("[TB] FAIL midop_fresh_read got ok=%0d err=%b rdata=%h want 1 0 ba", ok, er, rd);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            bit cli, we, ok, p1, oq; logic [5:0] a; logic [7:0] d, rd; logic er;
            cli = 1'(i % 2);
            we  = 1'($urandom_range(0, 1));
            a   = 6'($urandom_range(0, 63));
            d   = 8'($urandom_range(0, 255));
            do_req(cli, we, a, d, rd, er, ok, p1, oq);
            n_vec++;
            if (!ok || er !== 1'b0 || !p1 || (!we && rd !== exp_mem[a]) || (we && rd !== 8'h00)) begin
                n_err++;
                $display("[TB] FAIL mixed[%0d] cli=%0d we=%0d addr=%h got ok=%0d err=%b rdata=%h want err=0 rdata=%h",
                         i, cli, we, a, ok, er, rd, we ? 8'h00 : exp_mem[a]);
            end
            if (we) exp_mem[a] = d;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i) ^ 8'hB0;
        ifc.req0_valid = 1'b0; ifc.req0_we = 1'b0; ifc.req0_addr = '0; ifc.req0_wdata = '0;
        ifc.req1_valid = 1'b0; ifc.req1_we = 1'b0; ifc.req1_addr = '0; ifc.req1_wdata = '0;
        ifc_nw.req0_valid = 1'b0; ifc_nw.req0_we = 1'b0; ifc_nw.req0_addr = '0; ifc_nw.req0_wdata = '0;
        ifc_nw.req1_valid = 1'b0; ifc_nw.req1_we = 1'b0; ifc_nw.req1_addr = '0; ifc_nw.req1_wdata = '0;
        test_reset();
        test_read();
        test_write();
        test_no_wren();
        test_contention();
        test_timeout();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
